// File: rtl/fft_peak_detect_pkg.sv
// fft_peak_detect_pkg: shared constants, state encoding and helpers for the spectral peak detector
package fft_peak_detect_pkg;
  localparam int N = 256;
  localparam int POW_W = 34;
  localparam int BIN_LO = 1;
  localparam int BIN_HI = 127;
  localparam int CNT_W = 8;
  localparam int E_W = POW_W + 7;
  localparam int BIN_W = $clog2(N);
  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;
  typedef logic [BIN_W-1:0] bin_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: power-sample stream in, peak result record out on valid/ready
interface fft_peak_detect_if;
  import fft_peak_detect_pkg::*;
  logic frame_start;
  logic pwr_vld;
  logic [POW_W-1:0] pwr_din;
  logic [POW_W-1:0] thr_i;
  logic res_vld;
  logic res_rdy;
  bin_t res_bin;
  logic [POW_W-1:0] res_pwr;
  logic [E_W-1:0] res_energy;
  logic res_det;
  modport master(output frame_start, pwr_vld, pwr_din, thr_i, res_rdy,
                 input res_vld, res_bin, res_pwr, res_energy, res_det);
  modport slave(input frame_start, pwr_vld, pwr_din, thr_i, res_rdy,
                output res_vld, res_bin, res_pwr, res_energy, res_det);
endinterface

// File: rtl/fft_peak_acc.sv
// fft_peak_acc: windowed strict-greater peak search and energy accumulation, reloaded on BIN_LO
module fft_peak_acc
  import fft_peak_detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  bin_t             bin,
  input  logic [POW_W-1:0] pwr,
  output bin_t             nxt_bin,
  output logic [POW_W-1:0] nxt_pwr,
  output logic [E_W-1:0]   nxt_energy
);
  bin_t pk_bin;
  logic [POW_W-1:0] pk_pwr;
  logic [E_W-1:0] energy;
  logic in_win, load, upd;
  always_comb begin
    in_win = bin >= bin_t'(BIN_LO) && bin <= bin_t'(BIN_HI);
    load = bin == bin_t'(BIN_LO);
    upd = load || (in_win && pwr > pk_pwr);
    nxt_bin = upd ? bin : pk_bin;
    nxt_pwr = upd ? pwr : pk_pwr;
    nxt_energy = load ? E_W'(pwr) : in_win ? energy + E_W'(pwr) : energy;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pk_bin <= '0;
      pk_pwr <= '0;
      energy <= '0;
    end else if (vld) begin
      pk_bin <= nxt_bin;
      pk_pwr <= nxt_pwr;
      energy <= nxt_energy;
    end
endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame peak bin / window energy / threshold detection over a power-spectrum stream
module fft_peak_detect
  import fft_peak_detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fft_peak_detect_if.slave b,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);
  state_t state;
  bin_t bin_cnt, cur_bin, s1_bin, nxt_bin;
  logic [POW_W-1:0] thr_q, s1_pwr, nxt_pwr;
  logic [E_W-1:0] nxt_energy;
  logic s1_vld, s1_last, last, done;
  assign cur_bin = (b.frame_start || state == IDLE) ? '0 : bin_cnt;
  assign last = cur_bin == bin_t'(N - 1);
  assign done = s1_vld && s1_last;
  assign busy = state == ACC;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bin_cnt <= '0;
      thr_q <= '0;
      s1_vld <= 1'b0;
      s1_bin <= '0;
      s1_pwr <= '0;
      s1_last <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (b.frame_start && state == ACC && bin_cnt != '0) err_cnt <= sat_inc(err_cnt);
      s1_vld <= b.pwr_vld;
      if (b.pwr_vld) begin
        s1_bin <= cur_bin;
        s1_pwr <= b.pwr_din;
        s1_last <= last;
        if (cur_bin == '0) thr_q <= b.thr_i;
        state <= last ? IDLE : ACC;
        bin_cnt <= last ? '0 : cur_bin + 1'b1;
      end else if (b.frame_start) begin
        state <= IDLE;
        bin_cnt <= '0;
      end
    end
  fft_peak_acc u_acc (
    .clk(clk), .rst(rst), .vld(s1_vld), .bin(s1_bin), .pwr(s1_pwr),
    .nxt_bin(nxt_bin), .nxt_pwr(nxt_pwr), .nxt_energy(nxt_energy)
  );
  // A record finishing while an unaccepted one is held is dropped and counted
  always_ff @(posedge clk)
    if (rst) begin
      b.res_vld <= 1'b0;
      b.res_bin <= '0;
      b.res_pwr <= '0;
      b.res_energy <= '0;
      b.res_det <= 1'b0;
      ovf_cnt <= '0;
    end else if (done && (!b.res_vld || b.res_rdy)) begin
      b.res_vld <= 1'b1;
      b.res_bin <= nxt_bin;
      b.res_pwr <= nxt_pwr;
      b.res_energy <= nxt_energy;
      b.res_det <= nxt_pwr > thr_q;
    end else if (done) begin
      ovf_cnt <= sat_inc(ovf_cnt);
    end else if (b.res_rdy) begin
      b.res_vld <= 1'b0;
    end
endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Downstream consumer of the 256-point radix-4 FFT cache's power-spectrum stream. Each value is re^2+im^2, one bin per cycle, delivered in natural order after bit reversal.
- Per frame: finds the peak bin within a configurable search window and accumulates window energy.
- Compares the peak against a threshold and presents one result record per frame on a valid/ready handshake.
- Sits between the cache power output and the system result interface / host readout.

Parameters:
- N, 256, bins per frame
- POW_W, 34, power sample width (matches the cache data width)
- BIN_LO, 1, first bin searched (skips DC)
- BIN_HI, 127, last bin searched (positive half; input is real)
- CNT_W, 8, width of the overflow and error counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_start  in  1  pulse; next valid sample is bin 0; realigns the bin counter
- pwr_vld  in  1  pwr_din holds a valid bin this cycle
- pwr_din  in  POW_W  unsigned power sample
- thr_i  in  POW_W  detection threshold; sampled on bin 0
- res_vld  out  1  result record valid
- res_rdy  in  1  consumer accepts the record
- res_bin  out  8  index of the peak bin
- res_pwr  out  POW_W  power of the peak bin
- res_energy  out  POW_W+7  sum of power over BIN_LO..BIN_HI
- res_det  out  1  res_pwr > threshold
- ovf_cnt  out  CNT_W  frames dropped due to backpressure, saturating
- err_cnt  out  CNT_W  frames aborted by frame_start, saturating
- busy  out  1  frame accumulation in progress

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs and all internal state go to 0; FSM returns to IDLE.
  - Any partial frame and any pending result are discarded.
- FSM states:
  - IDLE: busy=0. First pwr_vld=1 sample is bin 0. Go to ACC.
  - ACC: busy=1. Each pwr_vld=1 sample advances bin_cnt by 1. After bin N-1, go to IDLE; a back-to-back next frame is accepted with no gap.
  - pwr_vld=0 cycles are idle cycles; the frame does not advance.
- frame_start:
  - In IDLE, or in ACC with bin_cnt==0: realigns only, not an error.
  - In ACC with bin_cnt≠0: partial frame discarded and err_cnt increments (saturating).
  - If pwr_vld=1 in the same cycle as frame_start, that sample is bin 0 of the new frame.
- Datapath (2-stage pipeline):
  - Stage 1 registers pwr_din, its bin index, and a last-bin flag.
  - Stage 2 updates peak and energy for bins in BIN_LO..BIN_HI.
  - Samples outside the window are ignored for both peak and energy.
  - On bin BIN_LO, peak and energy are loaded rather than compared/accumulated, so there is no carry-over between frames.
- Peak rule:
  - Replace the stored peak only when sample > stored (strict), so the lowest index wins ties.
  - An all-zero window reports res_bin=BIN_LO, res_pwr=0.
- Energy: unsigned accumulation, width POW_W+7. Cannot overflow for window length ≤128.
- Detection:
  - Threshold is latched when bin 0 is accepted; changes to thr_i mid-frame have no effect.
  - res_det = peak_pwr > latched threshold (strict).
- Latency: last bin (N-1) presented with pwr_vld=1 in cycle t → res_vld=1 in cycle t+2.
- Handshake:
  - Record and res_vld are held stable until res_vld&res_rdy at a clk edge; res_vld then drops the next cycle unless a new record completes that same edge.
  - A new record completing while res_vld=1 and the consumer does not accept at that edge: the new record is dropped, the old record is kept, ovf_cnt increments (saturating).
  - A new record completing at the same edge as acceptance: the new record loads, res_vld stays 1.
- Counters: saturate at 2^CNT_W-1; cleared only by rst.

Decomposition:
- Shared define file entries:
  - N, POW_W, BIN_LO, BIN_HI as global constants.
  - Energy width macro (POW_W+7).
  - FSM state encodings (IDLE=1'b0, ACC=1'b1).
- One natural sub-module: fft_peak_acc.
  - Stage-2 compare/accumulate datapath: window test, strict-greater peak update, energy add, load-on-BIN_LO.
  - The top holds the FSM, bin counter, threshold latch, result register/handshake and counters.

Test Plan:
- Tone: frame with bin 37 = 5000, all others 10, thr=1000, res_rdy=1 → res_bin=37, res_pwr=5000, res_energy=126*10+5000=6260, res_det=1, res_vld exactly 2 cycles after bin 255.
- Tie/edges: bins 20 and 90 both = 800, bin 0 = 99999, bin 200 = 99999 → res_bin=20, res_pwr=800; out-of-window bins are excluded from energy.
- Threshold strictness: peak=1000, thr=1000 → res_det=0; thr changed to 0 mid-frame → res_det still 0.
- Backpressure: res_rdy=0 over two consecutive frames → first record held, ovf_cnt=1; then res_rdy=1 → first record accepted, res_vld drops.
- Abort: frame_start after 100 bins, then a full frame → err_cnt=1 and exactly one record for the full frame.
- Reset mid-frame: rst at bin 150 with a pending record → all outputs 0 next cycle; a subsequent clean frame produces a correct record.
